// File: rtl/jk_pkg.sv
// Shared JK encodings and next-state helper for the JK register bank.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  function automatic logic jk_next(
    input logic q,
    input logic j,
    input logic k
  );
    logic r;
    r = q;
    case ({j, k})
      JK_HOLD:   r = q;
      JK_RESET:  r = 1'b0;
      JK_SET:    r = 1'b1;
      JK_TOGGLE: r = ~q;
      default:   r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK next-state block, gated by global enable and bit mask.
module jk_cell
  import jk_pkg::*;
(
  input  logic q,
  input  logic j,
  input  logic k,
  input  logic mask,
  input  logic en,
  output logic q_next
);

  assign q_next = (en & mask) ? jk_next(q, j, k) : q;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flags with clear/load priority and a change pulse.
// Optional saturating change counter: define JK_REG_BANK_CHG_CNT_EN.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             changed,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [WIDTH-1:0] q_jk;
  logic [WIDTH-1:0] q_next;
  logic             chg_pend;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .q      (q[i]),
      .j      (j[i]),
      .k      (k[i]),
      .mask   (mask[i]),
      .en     (en),
      .q_next (q_jk[i])
    );
  end

  always_comb begin
    q_next = q_jk;
    if (clr)
      q_next = '0;
    else if (load)
      q_next = load_data;
  end

  // chg_pend holds the diff one edge so changed lands a cycle after q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= RST_VAL;
      chg_pend <= 1'b0;
      changed  <= 1'b0;
    end else begin
      q        <= q_next;
      chg_pend <= (q_next != q);
      changed  <= chg_pend;
    end
  end

`ifdef JK_REG_BANK_CHG_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_r <= '0;
    else if (clr)
      cnt_r <= '0;
    else if (chg_pend && (cnt_r != {CNT_W{1'b1}}))
      cnt_r <= cnt_r + 1'b1;
  end

  assign chg_cnt = cnt_r;
`else
  assign chg_cnt = '0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed self-checking bench for jk_reg_bank.
module tb_jk_reg_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       load;
  logic [7:0] load_data;
  logic [7:0] mask;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] q;
  logic       changed;
  logic [1:0] chg_cnt;

  int n_checks = 0;
  int n_errors = 0;

  jk_reg_bank #(
    .WIDTH   (8),
    .RST_VAL (8'hA5),
    .CNT_W   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .load      (load),
    .load_data (load_data),
    .mask      (mask),
    .j         (j),
    .k         (k),
    .q         (q),
    .changed   (changed),
    .chg_cnt   (chg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 0; clr = 0; load = 0;
    load_data = 8'h00; mask = 8'h00;
    j = 8'h00; k = 8'h00;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (3) tick();
    n_checks++;
    if (q !== 8'hA5) begin
      n_errors++;
      $display("FAIL reset_q got %h exp a5", q);
    end
    n_checks++;
    if (changed !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_changed got %b exp 0", changed);
    end
    n_checks++;
    if (chg_cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_cnt got %0d exp 0", chg_cnt);
    end
    rst_n = 1;
    repeat (2) begin
      tick();
      n_checks++;
      if (q !== 8'hA5 || changed !== 1'b0) begin
        n_errors++;
        $display("FAIL release_hold got q=%h ch=%b exp a5/0", q, changed);
      end
    end
  endtask

  task automatic test_jk();
    clr = 1;
    tick();
    idle();
    tick();
    n_checks++;
    if (q !== 8'h00 || changed !== 1'b1) begin
      n_errors++;
      $display("FAIL jk_prep got q=%h ch=%b exp 00/1", q, changed);
    end
    en = 1; mask = 8'hFF; j = 8'h0F; k = 8'h00;
    tick();
    n_checks++;
    if (q !== 8'h0F || changed !== 1'b0) begin
      n_errors++;
      $display("FAIL jk_set got q=%h ch=%b exp 0f/0", q, changed);
    end
    j = 8'hFF; k = 8'hFF;
    tick();
    n_checks++;
    if (q !== 8'hF0 || changed !== 1'b1) begin
      n_errors++;
      $display("FAIL jk_tog1 got q=%h ch=%b exp f0/1", q, changed);
    end
    tick();
    n_checks++;
    if (q !== 8'h0F || changed !== 1'b1) begin
      n_errors++;
      $display("FAIL jk_tog2 got q=%h ch=%b exp 0f/1", q, changed);
    end
    en = 0;
    tick();
    tick();
    n_checks++;
    if (q !== 8'h0F || changed !== 1'b0) begin
      n_errors++;
      $display("FAIL jk_en0 got q=%h ch=%b exp 0f/0", q, changed);
    end
    j = 8'h00; k = 8'hFF; mask = 8'hFF; en = 1;
    tick();
    n_checks++;
    if (q !== 8'h00) begin
      n_errors++;
      $display("FAIL jk_reset got q=%h exp 00", q);
    end
    idle();
  endtask

  task automatic test_mask();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h01; exp_q[1] = 8'h00;
    exp_q[2] = 8'h01; exp_q[3] = 8'h00;
    clr = 1;
    tick();
    idle();
    en = 1; mask = 8'h01; j = 8'hFF; k = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (q !== exp_q[i]) begin
        n_errors++;
        $display("FAIL mask_tog%0d got %h exp %h", i, q, exp_q[i]);
      end
    end
    idle();
  endtask

  task automatic test_clr_load();
    load = 1; load_data = 8'hFF;
    tick();
    n_checks++;
    if (q !== 8'hFF) begin
      n_errors++;
      $display("FAIL load_ff got %h exp ff", q);
    end
    clr = 1; load = 1; load_data = 8'h3C;
    en = 1; mask = 8'hFF; j = 8'hFF; k = 8'h00;
    tick();
    n_checks++;
    if (q !== 8'h00) begin
      n_errors++;
      $display("FAIL clr_wins got %h exp 00", q);
    end
    clr = 0; en = 0;
    tick();
    n_checks++;
    if (q !== 8'h3C || changed !== 1'b1) begin
      n_errors++;
      $display("FAIL load_3c got q=%h ch=%b exp 3c/1", q, changed);
    end
    tick();
    n_checks++;
    if (q !== 8'h3C || changed !== 1'b1) begin
      n_errors++;
      $display("FAIL reload got q=%h ch=%b exp 3c/1", q, changed);
    end
    idle();
    tick();
    n_checks++;
    if (changed !== 1'b0) begin
      n_errors++;
      $display("FAIL reload_nochg got %b exp 0", changed);
    end
  endtask

  task automatic test_async_reset();
    load = 1; load_data = 8'h55;
    tick();
    idle();
    tick();
    n_checks++;
    if (q !== 8'h55 || changed !== 1'b1) begin
      n_errors++;
      $display("FAIL ar_prep got q=%h ch=%b exp 55/1", q, changed);
    end
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (q !== 8'hA5 || changed !== 1'b0 || chg_cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL async_rst got q=%h ch=%b c=%0d exp a5/0/0",
               q, changed, chg_cnt);
    end
    tick();
    rst_n = 1;
    tick();
    n_checks++;
    if (q !== 8'hA5 || changed !== 1'b0) begin
      n_errors++;
      $display("FAIL ar_release got q=%h ch=%b exp a5/0", q, changed);
    end
  endtask

  task automatic test_counter();
    logic [1:0] exp_c [6];
`ifdef JK_REG_BANK_CHG_CNT_EN
    exp_c[0] = 2'd0; exp_c[1] = 2'd1; exp_c[2] = 2'd2;
    exp_c[3] = 2'd3; exp_c[4] = 2'd3; exp_c[5] = 2'd3;
`else
    for (int i = 0; i < 6; i++) exp_c[i] = 2'd0;
`endif
    clr = 1;
    tick();
    tick();
    n_checks++;
    if (chg_cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL cnt_clr0 got %0d exp 0", chg_cnt);
    end
    idle();
    en = 1; mask = 8'h01; j = 8'hFF; k = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (chg_cnt !== exp_c[i]) begin
        n_errors++;
        $display("FAIL cnt_step%0d got %0d exp %0d",
                 i, chg_cnt, exp_c[i]);
      end
    end
    idle();
    tick();
    clr = 1;
    tick();
    n_checks++;
    if (chg_cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL cnt_clr got %0d exp 0", chg_cnt);
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_jk();
    test_mask();
    test_clr_load();
    test_async_reset();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
